// File: rtl/pq_pkg.sv
// Shared key/value types and LFSR constants for the HWPQ study blocks.
package pq_pkg;

  localparam int KEY_BITS = 8;
  localparam int VAL_BITS = 8;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] PQ_LFSR_POLY = 16'hB400;

  typedef struct packed {
    logic [KEY_BITS-1:0] key;
    logic [VAL_BITS-1:0] value;
  } kv_t;

  function automatic logic [15:0] pq_lfsr_next(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ PQ_LFSR_POLY) : (state >> 1);
  endfunction

endpackage

// File: rtl/pq_key_compare.sv
// Key-only ordering compare between two entries; value fields never affect priority.
module pq_key_compare
  import pq_pkg::*;
(
  input  kv_t  a,
  input  kv_t  b,
  output logic a_lt_b
);

  logic unused_values;

  assign a_lt_b        = (a.key < b.key);
  assign unused_values = ^{a.value, b.value};

endmodule

// File: rtl/pq_order_checker.sv
// Traffic source/sink for a priority queue: fills it with LFSR keys, drains it
// and counts every dequeued key that is smaller than its predecessor.
module pq_order_checker
  import pq_pkg::*;
#(
  parameter int          NUM_OPS = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        enq,
  output kv_t         kvi,
  input  logic        full,
  input  logic        busy,
  output logic        deq,
  input  kv_t         kvo,
  input  logic        empty,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] deq_count
);

  localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] OPS_TOTAL = 16'(NUM_OPS);
  localparam logic [15:0] OPS_LAST  = 16'(NUM_OPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [15:0]         lfsr_q;
  logic [15:0]         enq_idx_q;
  kv_t                 kvi_q;
  logic [KEY_BITS-1:0] prev_key_q;
  logic                first_q;
  logic [15:0]         err_count_q;
  logic [15:0]         err_count_d;
  logic [15:0]         deq_count_q;
  logic                done_q;
  logic                pass_q;

  logic run_start;
  logic clear_run;
  logic enq_fire;
  logic deq_fire;
  logic out_of_order;
  kv_t  kv_new;
  kv_t  prev_kv;

  // Strobes are decoded from state and the handshake inputs of the same cycle,
  // so a queue raising full/busy/empty blocks the strobe immediately.
  assign run_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign clear_run = (state_q == S_IDLE) || run_start;
  assign enq_fire  = (state_q == S_FILL) && !full && !busy;
  assign deq_fire  = (state_q == S_DRAIN) && !empty && !busy && (deq_count_q != OPS_TOTAL);

  assign kv_new  = '{key: lfsr_q[KEY_BITS-1:0], value: enq_idx_q[VAL_BITS-1:0]};
  assign prev_kv = '{key: prev_key_q, value: '0};

  assign err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : (err_count_q + 16'd1);

  pq_key_compare u_key_compare (
    .a      (kvo),
    .b      (prev_kv),
    .a_lt_b (out_of_order)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_INIT;
      enq_idx_q   <= '0;
      kvi_q       <= '0;
      prev_key_q  <= '0;
      first_q     <= 1'b1;
      err_count_q <= '0;
      deq_count_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      if (clear_run) begin
        lfsr_q      <= SEED_INIT;
        enq_idx_q   <= '0;
        first_q     <= 1'b1;
        err_count_q <= '0;
        deq_count_q <= '0;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (enq_fire) begin
            lfsr_q    <= pq_lfsr_next(lfsr_q);
            enq_idx_q <= enq_idx_q + 16'd1;
            kvi_q     <= kv_new;
            if (enq_idx_q == OPS_LAST) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // A leftover entry after the last dequeue shows up as empty = 0 here.
          if ((deq_count_q == OPS_TOTAL) || (empty && !busy)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == 16'd0) && (deq_count_q == OPS_TOTAL) && empty;
          end else if (deq_fire) begin
            if (!first_q && out_of_order) begin
              err_count_q <= err_count_d;
            end
            prev_key_q  <= kvo.key;
            first_q     <= 1'b0;
            deq_count_q <= deq_count_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign enq       = enq_fire;
  assign deq       = deq_fire;
  assign kvi       = enq_fire ? kv_new : kvi_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign deq_count = deq_count_q;

endmodule
